// File: rtl/ace_snoop_pkg.sv
// Shared types and constants for the ACE snoop sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ace_snoop_pkg;

    // Widest AC address the request struct can carry; narrower
    // configurations zero-extend into it.
    localparam int unsigned MaxAddrWidth = 64;

    // CRRESP bit positions
    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic [3:0]              snoop;
        logic [2:0]              prot;
    } ac_req_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CR,
        CD,
        DONE
    } state_e;

    // Number of CD beats that make up one cache line.
    function automatic int unsigned beats_per_line(input int unsigned line_bytes,
                                                   input int unsigned data_width);
        return (line_bytes * 8) / data_width;
    endfunction

endpackage

// File: rtl/snoop_req_fifo.sv
// Buffer of pending AC snoop requests (Depth entries of ac_req_t).
// Latency: head visible the cycle after push; data_o reflects the head combinationally.
// Backpressure: push ignored while full, pop ignored while empty; flags come from registered pointers.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-high reset
//   push_i, data_i       write request and entry
//   pop_i, data_o        consume head, head entry
//   full_o, empty_o      occupancy flags
module snoop_req_fifo
    import ace_snoop_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    push_i,
    input  ac_req_t data_i,
    input  logic    pop_i,
    output ac_req_t data_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    // One extra wrap bit distinguishes full from empty.
    logic [PtrW:0] wptr_q, wptr_d;
    logic [PtrW:0] rptr_q, rptr_d;
    ac_req_t       mem_q [Depth];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q[PtrW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[PtrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ace_snoop_sequencer.sv
// Serialises ACE snoops to the dcache: buffers AC, issues one at a time, forwards CR/CD, flags CD protocol errors.
// Latency: AC push to dc_ac_valid_o 2 cycles; CR/CD forwarded combinationally; 1 idle bubble between snoops.
// Backpressure: up_ac_ready_o drops when the FIFO is full; CR/CD ready is passed straight from upstream to the cache.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-high reset
//   up_ac_*                        snoop requests from the interconnect (valid/ready)
//   up_cr_*, up_cd_*               snoop response / data returned to the interconnect
//   dc_ac_*                        snoop request to the cache
//   dc_cr_*, dc_cd_*               snoop response / data from the cache
//   busy_o                         work pending or in flight
//   err_o                          sticky CD protocol violation
//   snoop_cnt_o                    completed snoops, wraps at 2^16
module ace_snoop_sequencer
    import ace_snoop_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,   // must not exceed MaxAddrWidth
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBytes = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // upstream AC
    input  logic                 up_ac_valid_i,
    output logic                 up_ac_ready_o,
    input  logic [AddrWidth-1:0] up_ac_addr_i,
    input  logic [3:0]           up_ac_snoop_i,
    input  logic [2:0]           up_ac_prot_i,
    // upstream CR
    output logic                 up_cr_valid_o,
    input  logic                 up_cr_ready_i,
    output logic [4:0]           up_cr_resp_o,
    // upstream CD
    output logic                 up_cd_valid_o,
    input  logic                 up_cd_ready_i,
    output logic [DataWidth-1:0] up_cd_data_o,
    output logic                 up_cd_last_o,
    // cache AC
    output logic                 dc_ac_valid_o,
    input  logic                 dc_ac_ready_i,
    output logic [AddrWidth-1:0] dc_ac_addr_o,
    output logic [3:0]           dc_ac_snoop_o,
    output logic [2:0]           dc_ac_prot_o,
    // cache CR
    input  logic                 dc_cr_valid_i,
    output logic                 dc_cr_ready_o,
    input  logic [4:0]           dc_cr_resp_i,
    // cache CD
    input  logic                 dc_cd_valid_i,
    output logic                 dc_cd_ready_o,
    input  logic [DataWidth-1:0] dc_cd_data_i,
    input  logic                 dc_cd_last_i,
    // status
    output logic                 busy_o,
    output logic                 err_o,
    output logic [15:0]          snoop_cnt_o
);

    localparam int unsigned Beats = beats_per_line(LineBytes, DataWidth);
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

    state_e          state_q, state_d;
    ac_req_t         req_q, req_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic            err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            init_q;

    ac_req_t         fifo_in;
    ac_req_t         fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            beat_is_last;

    // Ready is held low until the first clock after reset release.
    assign up_ac_ready_o = init_q & ~fifo_full;
    assign fifo_push     = up_ac_valid_i & up_ac_ready_o;

    always_comb begin
        fifo_in                      = '0;
        fifo_in.addr[AddrWidth-1:0]  = up_ac_addr_i;
        fifo_in.snoop                = up_ac_snoop_i;
        fifo_in.prot                 = up_ac_prot_i;
    end

    snoop_req_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign beat_is_last = (beat_q == LastBeat);

    // Request and response payloads are pure pass-through; only the
    // valid/ready pairs are gated by the state.
    assign dc_ac_addr_o  = req_q.addr[AddrWidth-1:0];
    assign dc_ac_snoop_o = req_q.snoop;
    assign dc_ac_prot_o  = req_q.prot;
    assign up_cr_resp_o  = dc_cr_resp_i;
    assign up_cd_data_o  = dc_cd_data_i;

    assign busy_o      = ~fifo_empty | (state_q != IDLE);
    assign err_o       = err_q;
    assign snoop_cnt_o = cnt_q;

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        beat_d        = beat_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        fifo_pop      = 1'b0;
        dc_ac_valid_o = 1'b0;
        dc_cr_ready_o = 1'b0;
        up_cr_valid_o = 1'b0;
        dc_cd_ready_o = 1'b0;
        up_cd_valid_o = 1'b0;
        up_cd_last_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dc_cd_valid_i) begin
                    err_d = 1'b1;
                end
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    req_d    = fifo_head;
                    state_d  = ISSUE;
                end
            end

            ISSUE: begin
                dc_ac_valid_o = 1'b1;
                if (dc_cd_valid_i) begin
                    err_d = 1'b1;
                end
                if (dc_ac_ready_i) begin
                    state_d = WAIT_CR;
                end
            end

            WAIT_CR: begin
                dc_cr_ready_o = up_cr_ready_i;
                up_cr_valid_o = dc_cr_valid_i;
                // The cache may present CD alongside a CR that announces data;
                // CD without such a CR beside it is unannounced.
                if (dc_cd_valid_i && !(dc_cr_valid_i && dc_cr_resp_i[CrDataTransfer])) begin
                    err_d = 1'b1;
                end
                if (dc_cr_valid_i && up_cr_ready_i) begin
                    beat_d  = '0;
                    state_d = dc_cr_resp_i[CrDataTransfer] ? CD : DONE;
                end
            end

            CD: begin
                dc_cd_ready_o = up_cd_ready_i;
                up_cd_valid_o = dc_cd_valid_i;
                up_cd_last_o  = beat_is_last;
                if (dc_cd_valid_i && up_cd_ready_i) begin
                    // The cache's own last flag is only cross-checked; the
                    // beat counter decides when the line is complete.
                    if (dc_cd_last_i != beat_is_last) begin
                        err_d = 1'b1;
                    end
                    if (beat_is_last) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end

            DONE: begin
                if (dc_cd_valid_i) begin
                    err_d = 1'b1;
                end
                cnt_d   = cnt_q + 16'd1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ace_snoop_sequencer.sv
// Self-checking bench for ace_snoop_sequencer: transaction-level model plus directed cache responses.
// Latency: n/a.
// Backpressure: upstream CR/CD ready held high; cache AC ready driven per test.
module tb_ace_snoop_sequencer;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int LB    = 16;
    localparam int FD    = 4;
    localparam int BEATS = LB * 8 / DW;
    localparam int TMO   = 50;

    logic          clk_i;
    logic          rst_ni;
    logic          up_ac_valid_i;
    logic          up_ac_ready_o;
    logic [AW-1:0] up_ac_addr_i;
    logic [3:0]    up_ac_snoop_i;
    logic [2:0]    up_ac_prot_i;
    logic          up_cr_valid_o;
    logic          up_cr_ready_i;
    logic [4:0]    up_cr_resp_o;
    logic          up_cd_valid_o;
    logic          up_cd_ready_i;
    logic [DW-1:0] up_cd_data_o;
    logic          up_cd_last_o;
    logic          dc_ac_valid_o;
    logic          dc_ac_ready_i;
    logic [AW-1:0] dc_ac_addr_o;
    logic [3:0]    dc_ac_snoop_o;
    logic [2:0]    dc_ac_prot_o;
    logic          dc_cr_valid_i;
    logic          dc_cr_ready_o;
    logic [4:0]    dc_cr_resp_i;
    logic          dc_cd_valid_i;
    logic          dc_cd_ready_o;
    logic [DW-1:0] dc_cd_data_i;
    logic          dc_cd_last_i;
    logic          busy_o;
    logic          err_o;
    logic [15:0]   snoop_cnt_o;

    ace_snoop_sequencer #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .LineBytes (LB),
        .FifoDepth (FD)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .up_ac_valid_i (up_ac_valid_i),
        .up_ac_ready_o (up_ac_ready_o),
        .up_ac_addr_i  (up_ac_addr_i),
        .up_ac_snoop_i (up_ac_snoop_i),
        .up_ac_prot_i  (up_ac_prot_i),
        .up_cr_valid_o (up_cr_valid_o),
        .up_cr_ready_i (up_cr_ready_i),
        .up_cr_resp_o  (up_cr_resp_o),
        .up_cd_valid_o (up_cd_valid_o),
        .up_cd_ready_i (up_cd_ready_i),
        .up_cd_data_o  (up_cd_data_o),
        .up_cd_last_o  (up_cd_last_o),
        .dc_ac_valid_o (dc_ac_valid_o),
        .dc_ac_ready_i (dc_ac_ready_i),
        .dc_ac_addr_o  (dc_ac_addr_o),
        .dc_ac_snoop_o (dc_ac_snoop_o),
        .dc_ac_prot_o  (dc_ac_prot_o),
        .dc_cr_valid_i (dc_cr_valid_i),
        .dc_cr_ready_o (dc_cr_ready_o),
        .dc_cr_resp_i  (dc_cr_resp_i),
        .dc_cd_valid_i (dc_cd_valid_i),
        .dc_cd_ready_o (dc_cd_ready_o),
        .dc_cd_data_i  (dc_cd_data_i),
        .dc_cd_last_i  (dc_cd_last_i),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .snoop_cnt_o   (snoop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    snoop;
        logic [2:0]    prot;
    } req_t;

    req_t        exp_q[$];      // accepted, not yet issued to the cache
    bit          m_aw_cr;       // snoop issued, CR not yet handed over
    bit          m_aw_cd;       // CR announced data, beats still owed
    int          m_beats;       // beats already transferred for this snoop
    bit          m_err;
    int unsigned m_cnt;
    bit          m_inc;         // a snoop completed; counter shows it one cycle later

    always @(negedge clk_i) begin
        bit issue_hs;
        if (rst_ni) begin
            exp_q.delete();
            m_aw_cr = 0;
            m_aw_cd = 0;
            m_beats = 0;
            m_err   = 0;
            m_cnt   = 0;
            m_inc   = 0;
            chk("rst_dc_ac_valid", dc_ac_valid_o, 0);
            chk("rst_up_cr_valid", up_cr_valid_o, 0);
            chk("rst_up_cd_valid", up_cd_valid_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_cnt", snoop_cnt_o, 0);
        end else begin
            issue_hs = 0;
            if (dc_ac_valid_o) begin
                if (m_aw_cr || m_aw_cd)
                    fail("single_outstanding");
                if (exp_q.size() == 0) begin
                    fail("issue_without_request");
                end else begin
                    chk("issue_addr_order", dc_ac_addr_o, exp_q[0].addr);
                    chk("issue_snoop", dc_ac_snoop_o, exp_q[0].snoop);
                    chk("issue_prot", dc_ac_prot_o, exp_q[0].prot);
                    if (dc_ac_ready_i) begin
                        void'(exp_q.pop_front());
                        issue_hs = 1;
                    end
                end
            end
            chk("up_cr_valid", up_cr_valid_o, m_aw_cr & dc_cr_valid_i);
            chk("dc_cr_ready", dc_cr_ready_o, m_aw_cr & up_cr_ready_i);
            if (m_aw_cr && dc_cr_valid_i)
                chk("up_cr_resp", up_cr_resp_o, dc_cr_resp_i);
            chk("up_cd_valid", up_cd_valid_o, m_aw_cd & dc_cd_valid_i);
            chk("dc_cd_ready", dc_cd_ready_o, m_aw_cd & up_cd_ready_i);
            if (m_aw_cd && dc_cd_valid_i) begin
                chk("up_cd_data", up_cd_data_o, dc_cd_data_i);
                chk("up_cd_last", up_cd_last_o, m_beats == BEATS - 1);
            end
            chk("err", err_o, m_err);
            chk("snoop_cnt", snoop_cnt_o, m_cnt[15:0]);

            // advance the model to what must hold after the coming edge
            m_cnt += m_inc;
            m_inc  = 0;
            if (up_ac_valid_i && up_ac_ready_o)
                exp_q.push_back('{addr: up_ac_addr_i, snoop: up_ac_snoop_i, prot: up_ac_prot_i});
            if (dc_cd_valid_i && !m_aw_cd && !(m_aw_cr && dc_cr_valid_i && dc_cr_resp_i[0]))
                m_err = 1;
            if (m_aw_cd && dc_cd_valid_i && up_cd_ready_i) begin
                if (dc_cd_last_i != (m_beats == BEATS - 1))
                    m_err = 1;
                m_beats++;
                if (m_beats == BEATS) begin
                    m_aw_cd = 0;
                    m_inc   = 1;
                end
            end
            if (m_aw_cr && dc_cr_valid_i && up_cr_ready_i) begin
                m_aw_cr = 0;
                if (dc_cr_resp_i[0]) begin
                    m_aw_cd = 1;
                    m_beats = 0;
                end else begin
                    m_inc = 1;
                end
            end
            if (issue_hs)
                m_aw_cr = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        up_ac_valid_i = 0;
        up_ac_addr_i  = '0;
        up_ac_snoop_i = '0;
        up_ac_prot_i  = '0;
        up_cr_ready_i = 1;
        up_cd_ready_i = 1;
        dc_ac_ready_i = 0;
        dc_cr_valid_i = 0;
        dc_cr_resp_i  = '0;
        dc_cd_valid_i = 0;
        dc_cd_data_i  = '0;
        dc_cd_last_i  = 0;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_up_ac_ready", up_ac_ready_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 0;
        @(negedge clk_i);
        chk("ready_before_first_edge", up_ac_ready_o, 0);
        @(negedge clk_i);
        chk("ready_after_reset", up_ac_ready_o, 1);
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [3:0] snoop, input logic [2:0] prot);
        bit ok = 0;
        @(posedge clk_i); #1;
        up_ac_valid_i = 1;
        up_ac_addr_i  = addr;
        up_ac_snoop_i = snoop;
        up_ac_prot_i  = prot;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (up_ac_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("timeout_push");
        @(posedge clk_i); #1;
        up_ac_valid_i = 0;
    endtask

    task automatic cache_accept(input logic [AW-1:0] exp_addr);
        bit ok = 0;
        @(posedge clk_i); #1;
        dc_ac_ready_i = 1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (dc_ac_valid_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail("timeout_issue");
        else     chk("issued_addr", dc_ac_addr_o, exp_addr);
        @(posedge clk_i); #1;
        dc_ac_ready_i = 0;
    endtask

    task automatic cache_cr(input logic [4:0] resp);
        bit ok = 0;
        @(posedge clk_i); #1;
        dc_cr_valid_i = 1;
        dc_cr_resp_i  = resp;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (dc_cr_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail("timeout_cr");
        end else begin
            chk("cr_fwd_valid", up_cr_valid_o, 1);
            chk("cr_fwd_resp", up_cr_resp_o, resp);
        end
        @(posedge clk_i); #1;
        dc_cr_valid_i = 0;
    endtask

    task automatic cache_cd(input logic [DW-1:0] data, input logic last, input logic exp_up_last);
        bit ok = 0;
        @(posedge clk_i); #1;
        dc_cd_valid_i = 1;
        dc_cd_data_i  = data;
        dc_cd_last_i  = last;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (dc_cd_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            fail("timeout_cd");
        end else begin
            chk("cd_fwd_valid", up_cd_valid_o, 1);
            chk("cd_fwd_data", up_cd_data_o, data);
            chk("cd_fwd_last", up_cd_last_o, exp_up_last);
        end
        @(posedge clk_i); #1;
        dc_cd_valid_i = 0;
        dc_cd_last_i  = 0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int            accepted;
        logic          ready_5th;
        logic [AW-1:0] exp_addrs [5];

        rst_ni = 1;
        clear_inputs();
        do_reset();

        // ReadShared with a two-beat line
        push(64'h8000_0040, 4'b0001, 3'b000);
        cache_accept(64'h8000_0040);
        cache_cr(5'b01001);
        cache_cd({4{16'hAAAA}}, 1'b0, 1'b0);
        cache_cd({4{16'hBBBB}}, 1'b1, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("t1_cnt", snoop_cnt_o, 16'd1);
        chk("t1_err", err_o, 0);

        // MakeInvalid: no data phase
        push(64'h8000_0080, 4'b1101, 3'b010);
        cache_accept(64'h8000_0080);
        cache_cr(5'b10000);
        repeat (3) @(negedge clk_i);
        chk("t2_cd_ready_idle", dc_cd_ready_o, 0);
        chk("t2_cnt", snoop_cnt_o, 16'd2);

        // FIFO fill while the cache stalls the AC channel
        push(64'h1000, 4'b0001, 3'b001);
        repeat (3) @(negedge clk_i);
        accepted  = 0;
        ready_5th = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            up_ac_valid_i = 1;
            up_ac_addr_i  = 64'h2000 + 64'(i) * 64'h40;
            up_ac_snoop_i = 4'b0001;
            up_ac_prot_i  = 3'b000;
            @(negedge clk_i);
            if (up_ac_ready_o) accepted++;
            if (i == 4) ready_5th = up_ac_ready_o;
        end
        @(posedge clk_i); #1;
        up_ac_valid_i = 0;
        chk("t3_accepted", 64'(accepted), 64'd4);
        chk("t3_ready_on_5th", ready_5th, 0);
        chk("t3_busy", busy_o, 1);
        exp_addrs[0] = 64'h1000;
        exp_addrs[1] = 64'h2000;
        exp_addrs[2] = 64'h2040;
        exp_addrs[3] = 64'h2080;
        exp_addrs[4] = 64'h20C0;
        for (int j = 0; j < 5; j++) begin
            cache_accept(exp_addrs[j]);
            cache_cr(5'b00000);
        end
        repeat (3) @(negedge clk_i);
        chk("t3_cnt", snoop_cnt_o, 16'd7);
        chk("t3_idle_busy", busy_o, 0);
        chk("t3_ready_back", up_ac_ready_o, 1);

        // Early last from the cache: error flagged, line still runs to two beats
        push(64'h8000_0100, 4'b0001, 3'b000);
        cache_accept(64'h8000_0100);
        cache_cr(5'b00001);
        cache_cd({4{16'h1111}}, 1'b1, 1'b0);
        chk("t4_err_after_beat0", err_o, 1);
        cache_cd({4{16'h2222}}, 1'b1, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("t4_err_sticky", err_o, 1);
        chk("t4_cnt", snoop_cnt_o, 16'd8);

        // Spurious CD while idle
        do_reset();
        @(posedge clk_i); #1;
        dc_cd_valid_i = 1;
        dc_cd_data_i  = {4{16'hDEAD}};
        @(negedge clk_i);
        chk("t5_not_consumed", dc_cd_ready_o, 0);
        chk("t5_not_forwarded", up_cd_valid_o, 0);
        chk("t5_err_before", err_o, 0);
        @(posedge clk_i); #1;
        dc_cd_valid_i = 0;
        @(negedge clk_i);
        chk("t5_err_set", err_o, 1);

        // Reset in the middle of the data phase
        do_reset();
        push(64'h8000_00C0, 4'b0001, 3'b000);
        cache_accept(64'h8000_00C0);
        cache_cr(5'b00001);
        cache_cd({4{16'hAAAA}}, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        rst_ni        = 1;
        dc_cd_valid_i = 1;
        dc_cd_data_i  = {4{16'hBBBB}};
        dc_cd_last_i  = 1;
        @(negedge clk_i);
        chk("t6_no_partial_cd", up_cd_valid_o, 0);
        chk("t6_cd_ready_low", dc_cd_ready_o, 0);
        chk("t6_busy_cleared", busy_o, 0);
        do_reset();
        push(64'h8000_0140, 4'b0001, 3'b000);
        cache_accept(64'h8000_0140);
        cache_cr(5'b01001);
        cache_cd({4{16'hCCCC}}, 1'b0, 1'b0);
        cache_cd({4{16'hDDDD}}, 1'b1, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("t6_cnt", snoop_cnt_o, 16'd1);
        chk("t6_err", err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ace_snoop_sequencer.md
Name: ace_snoop_sequencer

Overview:
- Sits between the interconnect snoop master and the std_nbdcache snoop port (snoop_port_i/snoop_port_o).
- Accepts ACE snoop requests on an upstream AC channel and buffers them in a small FIFO.
- Issues requests to the cache strictly one at a time and collects the CR response plus any CD data beats.
- Forwards CR/CD upstream and flags protocol violations: data-beat count mismatch, or CD present when not announced.

Parameters:
- AddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- LineBytes, 16, cache line size; beats per line = LineBytes*8/DataWidth.
- FifoDepth, 4, AC request buffer entries (power of 2, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-high
- up_ac_valid_i  in  1  upstream snoop request valid
- up_ac_ready_o  out  1  FIFO not full
- up_ac_addr_i  in  AddrWidth  snoop address
- up_ac_snoop_i  in  4  ACSNOOP
- up_ac_prot_i  in  3  ACPROT
- up_cr_valid_o  out  1  response to interconnect
- up_cr_ready_i  in  1
- up_cr_resp_o  out  5  CRRESP
- up_cd_valid_o  out  1
- up_cd_ready_i  in  1
- up_cd_data_o  out  DataWidth
- up_cd_last_o  out  1  regenerated from the beat counter
- dc_ac_valid_o  out  1  request to cache
- dc_ac_ready_i  in  1
- dc_ac_addr_o  out  AddrWidth
- dc_ac_snoop_o  out  4
- dc_ac_prot_o  out  3
- dc_cr_valid_i  in  1
- dc_cr_ready_o  out  1
- dc_cr_resp_i  in  5
- dc_cd_valid_i  in  1
- dc_cd_ready_o  out  1
- dc_cd_data_i  in  DataWidth
- dc_cd_last_i  in  1
- busy_o  out  1  FIFO non-empty or FSM not IDLE
- err_o  out  1  sticky protocol error
- snoop_cnt_o  out  16  completed snoops, wraps

Behaviour:
- Reset: all valid outputs 0, err_o 0, snoop_cnt_o 0, FIFO empty, FSM IDLE. up_ac_ready_o is 1 one cycle after reset deasserts.
- FIFO push on up_ac_valid_i & up_ac_ready_o. up_ac_ready_o = !full.
- Simultaneous push and pop when full: push is refused, because ready is computed from the registered full flag.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into a holding register and go to ISSUE next cycle.
  - ISSUE: dc_ac_valid_o = 1, held stable until dc_ac_ready_i; then go to WAIT_CR.
  - WAIT_CR: dc_cr_ready_o = up_cr_ready_i; up_cr_valid_o = dc_cr_valid_i (combinational pass-through, zero latency).
    - On handshake, latch CRRESP[0] (DataTransfer).
    - If DataTransfer = 1, go to CD; else go to DONE.
  - CD: dc_cd_ready_o = up_cd_ready_i; up_cd_valid_o = dc_cd_valid_i; beat counter increments per handshake; up_cd_last_o = (cnt == Beats-1).
    - After the last beat, go to DONE.
    - If dc_cd_last_i differs from the computed last on any beat, set err_o; the computed last still governs termination.
  - DONE: snoop_cnt_o += 1 (wraps at 2^16); go to IDLE. Minimum 1 idle bubble between snoops.
- CR and CD may both be valid from the cache in the same cycle. CD is not accepted before the CR handshake (dc_cd_ready_o = 0 outside CD).
- dc_cd_valid_i observed high in IDLE/ISSUE/WAIT_CR, or in CD after the last beat → err_o set; the beat is not consumed.
- The snoop is never issued to the cache before the previous CR/CD completes (single outstanding).
- Reset mid-transaction: everything cleared immediately (async); in-flight snoop discarded, no partial CR/CD forwarded after reset.

Decomposition:
- Shared package ace_snoop_pkg holds:
  - ac_req_t struct {addr, snoop, prot}
  - state enum {IDLE, ISSUE, WAIT_CR, CD, DONE}
  - CRRESP bit index constants (DataTransfer=0, Error=1, PassDirty=2, IsShared=3, WasUnique=4)
- One sub-module: snoop_req_fifo, a generic FifoDepth x ac_req_t FIFO with full/empty flags.

Test Plan:
- Single ReadShared (acsnoop 4'b0001) at 0x8000_0040; cache returns CRRESP 5'b01001 then 2 beats 0xAAAA…, 0xBBBB… → upstream sees CR 5'b01001, two CD beats with last on the second; snoop_cnt_o = 1; err_o = 0.
- MakeInvalid (4'b1101) at 0x8000_0080; CRRESP 5'b10000 → no CD forwarded; dc_cd_ready_o stays 0; cnt increments.
- Push 5 requests back-to-back with dc_ac_ready_i = 0 → 4 accepted, up_ac_ready_o drops on the 5th. After release, they are issued to the cache in order, one at a time.
- CRRESP DataTransfer = 1, but cache raises dc_cd_last_i on beat 0 → err_o = 1 (sticky); 2 beats are still forwarded; up_cd_last_o is set on beat 1.
- Spurious dc_cd_valid_i in IDLE → err_o = 1; beat not consumed.
- Assert reset during the CD state after beat 0 → all outputs return to reset values; the next snoop completes normally with 2 beats.
